// File: rtl/man_pkg.sv
// Shared types and sprite artwork for the running-man datapath.
`timescale 1ns/1ps
package man_pkg;

    typedef logic [2:0] COLOUR_T;

    localparam int DEF_SPRITE_W = 8;
    localparam int DEF_SPRITE_H = 8;

    localparam COLOUR_T DEF_MAN_COLOUR = 3'b111;
    localparam COLOUR_T DEF_BG_COLOUR  = 3'b000;

    // Indexed [row][col]; rows are listed bottom (row 7) to top (row 0), bit 0 is the leftmost column.
    typedef logic [DEF_SPRITE_H-1:0][DEF_SPRITE_W-1:0] mask_t;

    localparam mask_t POSE0_MASK = {
        8'b01000010, 8'b01000010, 8'b00100100, 8'b00011000,
        8'b01011010, 8'b00111100, 8'b00011000, 8'b00011000
    };

    localparam mask_t POSE1_MASK = {
        8'b00100100, 8'b00100100, 8'b00011000, 8'b00011000,
        8'b00111100, 8'b01011010, 8'b00011000, 8'b00011000
    };

endpackage

// File: rtl/man_physics.sv
// Horizontal run, jump and gravity state for the running man; advances one step per update.
`timescale 1ns/1ps
module man_physics
    import man_pkg::*;
#(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8,
    parameter int SCREEN_W = 160,
    parameter int START_X  = 8,
    parameter int FLOOR_Y  = 100,
    parameter int STEP_X   = 2,
    parameter int JUMP_V   = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       update_i,
    input  logic       jump_i,
    output logic [7:0] pos_x_o,
    output logic [6:0] pos_y_o
);

    localparam logic [6:0]        GROUND_Y = 7'(FLOOR_Y - SPRITE_H);
    localparam logic signed [8:0] GROUND_S = 9'(FLOOR_Y - SPRITE_H);
    localparam logic [8:0]        X_LIMIT  = 9'(SCREEN_W - SPRITE_W);

    logic [7:0]        pos_x_q, pos_x_d;
    logic [6:0]        pos_y_q, pos_y_d;
    logic signed [4:0] vel_q, vel_d;
    logic              jump_req_q, jump_req_d;

    logic              grounded;
    logic [8:0]        sum_x;
    logic signed [4:0] vel_n;
    logic signed [8:0] ny;

    always_comb begin
        grounded = (pos_y_q == GROUND_Y) && (vel_q == 5'sd0);
        sum_x    = {1'b0, pos_x_q} + 9'(STEP_X);

        if (grounded && jump_req_q) begin
            vel_n = -(5'(JUMP_V));
        end else if (!grounded) begin
            vel_n = vel_q + 5'sd1;
        end else begin
            vel_n = 5'sd0;
        end
        ny = signed'({2'b00, pos_y_q}) + {{4{vel_n[4]}}, vel_n};

        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        vel_d   = vel_q;
        if (update_i) begin
            pos_x_d = (sum_x > X_LIMIT) ? 8'd0 : sum_x[7:0];
            if (ny >= GROUND_S) begin
                pos_y_d = GROUND_Y;
                vel_d   = 5'sd0;
            end else begin
                pos_y_d = ny[6:0];
                vel_d   = vel_n;
            end
        end

        // Only a grounded update consumes the request; mid-air requests survive until landing.
        jump_req_d = (update_i && grounded) ? 1'b0 : (jump_req_q | jump_i);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pos_x_q    <= 8'(START_X);
            pos_y_q    <= GROUND_Y;
            vel_q      <= 5'sd0;
            jump_req_q <= 1'b0;
        end else begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            vel_q      <= vel_d;
            jump_req_q <= jump_req_d;
        end
    end

    assign pos_x_o = pos_x_q;
    assign pos_y_o = pos_y_q;

endmodule

// File: rtl/man_sprite_datapath.sv
// Sprite scan/colour datapath for the running man, fed by the game control FSM.
// MAN_FRAME_COUNTER_EN enables the saturating frame counter; otherwise frame_count is tied to 0.
`timescale 1ns/1ps
module man_sprite_datapath
    import man_pkg::*;
#(
    parameter int      SPRITE_W   = 8,
    parameter int      SPRITE_H   = 8,
    parameter int      SCREEN_W   = 160,
    parameter int      START_X    = 8,
    parameter int      FLOOR_Y    = 100,
    parameter int      STEP_X     = 2,
    parameter int      JUMP_V     = 6,
    parameter COLOUR_T MAN_COLOUR = DEF_MAN_COLOUR,
    parameter COLOUR_T BG_COLOUR  = DEF_BG_COLOUR
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ld_x,
    input  logic       ld_y,
    input  logic       ld_man_style,
    input  logic       draw_man,
    input  logic       erase,
    input  logic       update,
    input  logic       jump,
    input  logic       frame_tick,
    input  logic       reset_frame_counter,
    output logic [7:0] x,
    output logic [6:0] y,
    output COLOUR_T    colour,
    output logic       drawing_man_finish,
    output logic       erase_finish,
    output logic [3:0] frame_count
);

    localparam int CXW = $clog2(SPRITE_W);
    localparam int CYW = $clog2(SPRITE_H);

    logic [7:0]     pos_x, org_x_q, org_x_d;
    logic [6:0]     pos_y, org_y_q, org_y_d;
    logic           style_q, style_d;
    logic [CXW-1:0] cnt_x_q, cnt_x_d;
    logic [CYW-1:0] cnt_y_q, cnt_y_d;
    logic           active, last_pixel;
    mask_t          pose_mask;

    man_physics #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .SCREEN_W (SCREEN_W),
        .START_X  (START_X),
        .FLOOR_Y  (FLOOR_Y),
        .STEP_X   (STEP_X),
        .JUMP_V   (JUMP_V)
    ) u_physics (
        .clk      (clk),
        .reset_n  (reset_n),
        .update_i (update),
        .jump_i   (jump),
        .pos_x_o  (pos_x),
        .pos_y_o  (pos_y)
    );

    always_comb begin
        active     = draw_man | erase;
        last_pixel = (cnt_x_q == CXW'(SPRITE_W - 1)) && (cnt_y_q == CYW'(SPRITE_H - 1));

        org_x_d = org_x_q;
        org_y_d = org_y_q;
        style_d = style_q;
        cnt_x_d = '0;
        cnt_y_d = '0;
        if (active) begin
            if (cnt_x_q == CXW'(SPRITE_W - 1)) begin
                cnt_y_d = (cnt_y_q == CYW'(SPRITE_H - 1)) ? '0 : cnt_y_q + 1'b1;
            end else begin
                cnt_x_d = cnt_x_q + 1'b1;
                cnt_y_d = cnt_y_q;
            end
        end else begin
            // Origin and pose are frozen for the whole scan so a box is never torn.
            if (ld_x)         org_x_d = pos_x;
            if (ld_y)         org_y_d = pos_y;
            if (ld_man_style) style_d = ~style_q;
        end

        pose_mask = style_q ? POSE1_MASK : POSE0_MASK;
        if (erase) begin
            colour = BG_COLOUR;
        end else if (draw_man && pose_mask[cnt_y_q][cnt_x_q]) begin
            colour = MAN_COLOUR;
        end else begin
            colour = BG_COLOUR;
        end

        drawing_man_finish = last_pixel && draw_man && !erase;
        erase_finish       = last_pixel && erase;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            org_x_q <= 8'(START_X);
            org_y_q <= 7'(FLOOR_Y - SPRITE_H);
            style_q <= 1'b0;
            cnt_x_q <= '0;
            cnt_y_q <= '0;
        end else begin
            org_x_q <= org_x_d;
            org_y_q <= org_y_d;
            style_q <= style_d;
            cnt_x_q <= cnt_x_d;
            cnt_y_q <= cnt_y_d;
        end
    end

    assign x = org_x_q + 8'(cnt_x_q);
    assign y = org_y_q + 7'(cnt_y_q);

`ifdef MAN_FRAME_COUNTER_EN
    logic [3:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (!reset_frame_counter) begin
            frame_cnt_d = 4'd0;
        end else if (frame_tick && (frame_cnt_q != 4'hF)) begin
            frame_cnt_d = frame_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_cnt_q <= 4'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_count = frame_cnt_q;
`else
    logic unused_frame_inputs;
    assign unused_frame_inputs = frame_tick ^ reset_frame_counter;
    assign frame_count         = 4'd0;
`endif

endmodule

// File: tb/tb_man_sprite_datapath.sv
// Directed self-checking bench for man_sprite_datapath: scans, physics steps and frame counter.
`timescale 1ns/1ps
module tb_man_sprite_datapath;

    logic       clk = 1'b0;
    logic       reset_n, ld_x, ld_y, ld_man_style, draw_man, erase, update, jump;
    logic       frame_tick, reset_frame_counter;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       drawing_man_finish, erase_finish;
    logic [3:0] frame_count;

    int checks   = 0;
    int failures = 0;

    // Hand-copied sprite art: element r is row r, bit c is column c.
    logic [7:0] p0 [8] = '{8'b00011000, 8'b00011000, 8'b00111100, 8'b01011010,
                           8'b00011000, 8'b00100100, 8'b01000010, 8'b01000010};
    logic [7:0] p1 [8] = '{8'b00011000, 8'b00011000, 8'b01011010, 8'b00111100,
                           8'b00011000, 8'b00011000, 8'b00100100, 8'b00100100};

    always #5 clk = ~clk;

    man_sprite_datapath dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .ld_x                (ld_x),
        .ld_y                (ld_y),
        .ld_man_style        (ld_man_style),
        .draw_man            (draw_man),
        .erase               (erase),
        .update              (update),
        .jump                (jump),
        .frame_tick          (frame_tick),
        .reset_frame_counter (reset_frame_counter),
        .x                   (x),
        .y                   (y),
        .colour              (colour),
        .drawing_man_finish  (drawing_man_finish),
        .erase_finish        (erase_finish),
        .frame_count         (frame_count)
    );

    function automatic logic [2:0] exp_col(input bit st, input int r, input int c);
        logic [7:0] row;
        row = st ? p1[r] : p0[r];
        return row[c] ? 3'b111 : 3'b000;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0; ld_x = 0; ld_y = 0; ld_man_style = 0; draw_man = 0; erase = 0;
        update = 0; jump = 0; frame_tick = 0; reset_frame_counter = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic pulse_update();
        @(negedge clk); update = 1'b1;
        @(negedge clk); update = 1'b0;
    endtask

    task automatic pulse_jump();
        @(negedge clk); jump = 1'b1;
        @(negedge clk); jump = 1'b0;
    endtask

    task automatic latch_pos();
        @(negedge clk); ld_x = 1'b1; ld_y = 1'b1;
        @(negedge clk); ld_x = 1'b0; ld_y = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (x !== 8'd8) begin failures++; $display("FAIL reset_x got=%0d exp=8", x); end
        checks++; if (y !== 7'd92) begin failures++; $display("FAIL reset_y got=%0d exp=92", y); end
        checks++; if (colour !== 3'b000) begin failures++; $display("FAIL reset_colour got=%b exp=000", colour); end
        checks++; if ({drawing_man_finish, erase_finish} !== 2'b00) begin
            failures++; $display("FAIL reset_flags got=%b exp=00", {drawing_man_finish, erase_finish}); end
        checks++; if (frame_count !== 4'd0) begin failures++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count); end
        $display("reset: x=%0d y=%0d colour=%b", x, y, colour);
    endtask

    task automatic test_draw();
        apply_reset();
        @(negedge clk); draw_man = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1;
            checks++; if (x !== 8'(8 + i % 8) || y !== 7'(92 + i / 8)) begin
                failures++; $display("FAIL draw_xy pix=%0d got=(%0d,%0d) exp=(%0d,%0d)", i, x, y, 8 + i % 8, 92 + i / 8); end
            checks++; if (colour !== exp_col(1'b0, i / 8, i % 8)) begin
                failures++; $display("FAIL draw_colour pix=%0d got=%b exp=%b", i, colour, exp_col(1'b0, i / 8, i % 8)); end
            checks++; if (drawing_man_finish !== (i == 63) || erase_finish !== 1'b0) begin
                failures++; $display("FAIL draw_finish pix=%0d got=%b%b exp=%b0", i, drawing_man_finish, erase_finish, i == 63); end
            @(negedge clk);
        end
        #1;
        checks++; if (x !== 8'd8 || y !== 7'd92 || drawing_man_finish !== 1'b0) begin
            failures++; $display("FAIL draw_wrap got=(%0d,%0d,%b) exp=(8,92,0)", x, y, drawing_man_finish); end
        draw_man = 1'b0;
        $display("draw: 64-pixel pose0 scan done");
    endtask

    task automatic test_erase();
        apply_reset();
        @(negedge clk); draw_man = 1'b1; erase = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1;
            checks++; if (colour !== 3'b000) begin failures++; $display("FAIL erase_colour pix=%0d got=%b exp=000", i, colour); end
            checks++; if (erase_finish !== (i == 63) || drawing_man_finish !== 1'b0) begin
                failures++; $display("FAIL erase_finish pix=%0d got=e%b d%b exp=e%b d0", i, erase_finish, drawing_man_finish, i == 63); end
            @(negedge clk);
        end
        draw_man = 1'b0; erase = 1'b0;
        $display("erase: 64-pixel erase scan done");
    endtask

    task automatic test_style_midscan();
        apply_reset();
        @(negedge clk); draw_man = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ld_man_style = (i == 10);
            update       = (i == 20);
            ld_x         = (i == 25);
            #1;
            checks++; if (x !== 8'(8 + i % 8) || colour !== exp_col(1'b0, i / 8, i % 8)) begin
                failures++; $display("FAIL midscan pix=%0d got=(%0d,%b) exp=(%0d,%b)", i, x, colour, 8 + i % 8, exp_col(1'b0, i / 8, i % 8)); end
            @(negedge clk);
        end
        draw_man = 1'b0; ld_man_style = 1'b1; update = 1'b0; ld_x = 1'b0;
        @(negedge clk); ld_man_style = 1'b0; draw_man = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1;
            checks++; if (x !== 8'(8 + i % 8) || colour !== exp_col(1'b1, i / 8, i % 8)) begin
                failures++; $display("FAIL pose1 pix=%0d got=(%0d,%b) exp=(%0d,%b)", i, x, colour, 8 + i % 8, exp_col(1'b1, i / 8, i % 8)); end
            @(negedge clk);
        end
        draw_man = 1'b0;
        $display("style: mid-scan loads ignored, idle toggle gives pose1");
    endtask

    task automatic test_reset_midscan();
        apply_reset();
        @(negedge clk); draw_man = 1'b1;
        for (int i = 0; i < 30; i++) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk); reset_n = 1'b1;
        for (int j = 0; j < 40; j++) begin
            #1;
            checks++; if (drawing_man_finish !== 1'b0 || x !== 8'(8 + j % 8) || y !== 7'(92 + j / 8)) begin
                failures++; $display("FAIL reset_midscan pix=%0d got=(%0d,%0d,%b) exp=(%0d,%0d,0)", j, x, y, drawing_man_finish, 8 + j % 8, 92 + j / 8); end
            @(negedge clk);
        end
        draw_man = 1'b0;
        $display("reset_midscan: scan restarted from 0 with no finish pulse");
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int k = 0; k < 71; k++) pulse_update();
        latch_pos();
        checks++; if (x !== 8'd150 || y !== 7'd92) begin failures++; $display("FAIL wrap_150 got=(%0d,%0d) exp=(150,92)", x, y); end
        pulse_update(); latch_pos();
        checks++; if (x !== 8'd152) begin failures++; $display("FAIL wrap_152 got=%0d exp=152", x); end
        pulse_update(); latch_pos();
        checks++; if (x !== 8'd0) begin failures++; $display("FAIL wrap_0 got=%0d exp=0", x); end
        $display("wrap: pos_x 150 -> 152 -> 0");
    endtask

    task automatic test_jump();
        int exp_y [13] = '{86, 81, 77, 74, 72, 71, 71, 72, 74, 77, 81, 86, 92};
        apply_reset();
        pulse_jump();
        for (int k = 0; k < 13; k++) begin
            pulse_update(); latch_pos();
            checks++; if (y !== 7'(exp_y[k])) begin failures++; $display("FAIL jump_y step=%0d got=%0d exp=%0d", k, y, exp_y[k]); end
        end
        pulse_update(); latch_pos();
        checks++; if (y !== 7'd92) begin failures++; $display("FAIL jump_grounded got=%0d exp=92", y); end
        $display("jump: arc 86..71..92 then grounded");
    endtask

    task automatic test_jump_retain();
        apply_reset();
        pulse_jump(); pulse_update();
        pulse_jump();
        for (int k = 0; k < 12; k++) pulse_update();
        latch_pos();
        checks++; if (y !== 7'd92) begin failures++; $display("FAIL retain_land got=%0d exp=92", y); end
        pulse_update(); latch_pos();
        checks++; if (y !== 7'd86) begin failures++; $display("FAIL retain_rejump got=%0d exp=86", y); end
        $display("jump_retain: airborne request re-jumps after landing");
    endtask

    task automatic test_frame_counter();
        apply_reset();
        @(negedge clk); frame_tick = 1'b1;
        for (int k = 0; k < 19; k++) @(negedge clk);
        @(negedge clk); frame_tick = 1'b0;
        #1;
`ifdef MAN_FRAME_COUNTER_EN
        checks++; if (frame_count !== 4'd15) begin failures++; $display("FAIL frame_saturate got=%0d exp=15", frame_count); end
        frame_tick = 1'b1; reset_frame_counter = 1'b0;
        @(negedge clk); frame_tick = 1'b0; reset_frame_counter = 1'b1;
        #1;
        checks++; if (frame_count !== 4'd0) begin failures++; $display("FAIL frame_clear got=%0d exp=0", frame_count); end
        frame_tick = 1'b1;
        for (int k = 0; k < 3; k++) @(negedge clk);
        frame_tick = 1'b0;
        #1;
        checks++; if (frame_count !== 4'd3) begin failures++; $display("FAIL frame_count3 got=%0d exp=3", frame_count); end
`else
        checks++; if (frame_count !== 4'd0) begin failures++; $display("FAIL frame_disabled got=%0d exp=0", frame_count); end
`endif
        $display("frame_counter: frame_count=%0d", frame_count);
    endtask

    initial begin
        test_reset();
        test_draw();
        test_erase();
        test_style_midscan();
        test_reset_midscan();
        test_wrap();
        test_jump();
        test_jump_retain();
        test_frame_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
